// File: rtl/ram_mp_arb.sv
// Multi-port word RAM behind a round-robin arbiter, byte enables, registered read.
// Optional macro RAM_MP_CLEAR_EN zero-fills the array after reset before granting.
module ram_mp_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 1024,
   parameter int NUM_PORTS  = 2
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic [NUM_PORTS-1:0]            en,
   input  logic [NUM_PORTS-1:0]            wr_rdn,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_wr,
   input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] be,
   output logic [NUM_PORTS-1:0]            gnt,
   output logic [NUM_PORTS-1:0]            rd_valid,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] data_rd,
   output logic [NUM_PORTS-1:0]            addr_err,
   output logic                            init_done
);

   localparam int BW = DATA_WIDTH / 8;
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0]             ptr_q, ptr_d;
   logic                      init_done_q, init_done_d;
   logic [NUM_PORTS-1:0]      rd_valid_q, addr_err_q;
   logic [NUM_PORTS*DATA_WIDTH-1:0] data_rd_q;

   logic [NUM_PORTS-1:0]      gnt_c;
   logic [PW-1:0]             win;
   logic                      acc;
   int                        idx;

   logic                      sel_wr;
   logic [ADDR_WIDTH-1:0]     sel_addr;
   logic [DATA_WIDTH-1:0]     sel_wdata;
   logic [BW-1:0]             sel_be;
   logic                      in_range;
   logic [IW-1:0]             widx;
   logic                      wr_fire;

   logic                      clr_we;
   logic [IW-1:0]             clr_idx;

   // Rotating priority search starting at the pointer
   always_comb begin
      gnt_c = '0;
      win   = '0;
      acc   = 1'b0;
      idx   = 0;
      if (init_done_q) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!acc && en[PW'(idx)]) begin
               acc = 1'b1;
               win = PW'(idx);
            end
         end
      end
      if (acc) gnt_c[win] = 1'b1;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (acc) begin
         if (int'(win) == NUM_PORTS - 1) ptr_d = '0;
         else ptr_d = win + PW'(1);
      end
   end

   assign sel_wr    = wr_rdn[win];
   assign sel_addr  = addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
   assign sel_wdata = data_wr[int'(win)*DATA_WIDTH +: DATA_WIDTH];
   assign sel_be    = be[int'(win)*BW +: BW];
   assign in_range  = {1'b0, sel_addr} < (ADDR_WIDTH+1)'(DEPTH);
   assign widx      = sel_addr[IW-1:0];
   assign wr_fire   = acc && sel_wr && in_range;

`ifdef RAM_MP_CLEAR_EN
   typedef enum logic {INIT, READY} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] clr_q, clr_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= INIT;
         clr_q   <= '0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      clr_we  = 1'b0;
      unique case (state_q)
         INIT: begin
            clr_we = 1'b1;
            if (int'(clr_q) == DEPTH - 1) state_d = READY;
            else clr_d = clr_q + IW'(1);
         end
         READY: state_d = READY;
         default: state_d = INIT;
      endcase
   end

   assign clr_idx     = clr_q;
   assign init_done_d = (state_q == READY);
`else
   assign clr_we      = 1'b0;
   assign clr_idx     = '0;
   assign init_done_d = 1'b1;
`endif

   // Storage is deliberately not reset
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem_q[clr_idx] <= '0;
      end else if (wr_fire) begin
         for (int b = 0; b < BW; b++) begin
            if (sel_be[b]) mem_q[widx][8*b +: 8] <= sel_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr_q       <= '0;
         init_done_q <= 1'b0;
         rd_valid_q  <= '0;
         addr_err_q  <= '0;
         data_rd_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         init_done_q <= init_done_d;
         rd_valid_q  <= '0;
         addr_err_q  <= '0;
         if (acc) begin
            addr_err_q[win] <= !in_range;
            if (!sel_wr) begin
               rd_valid_q[win] <= 1'b1;
               data_rd_q[int'(win)*DATA_WIDTH +: DATA_WIDTH] <=
                  in_range ? mem_q[widx] : '0;
            end
         end
      end
   end

   assign gnt       = gnt_c;
   assign rd_valid  = rd_valid_q;
   assign addr_err  = addr_err_q;
   assign data_rd   = data_rd_q;
   assign init_done = init_done_q;

endmodule

// File: doc/ram_mp_arb.md
Name: ram_mp_arb

Overview:
- Parametrised successor to the team's single-port ram block.
- Single-clock word RAM shared by NUM_PORTS requesters through a round-robin arbiter.
- Adds per-byte write enables, a registered read with valid pulse, and a configurable depth with out-of-range detection.
- Sits between several bus masters (DMA, CPU) and one storage array.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, address width in bits.
- DEPTH, 1024, number of implemented words; must be at most 2**ADDR_WIDTH.
- NUM_PORTS, 2, number of requester ports; must be at least 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- en  in  NUM_PORTS  per-port request valid.
- wr_rdn  in  NUM_PORTS  per-port direction: 1 = write, 0 = read.
- addr  in  NUM_PORTS*ADDR_WIDTH  per-port address, port p at bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- data_wr  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- be  in  NUM_PORTS*(DATA_WIDTH/8)  per-port byte enables; bit i covers data bits [8i+7:8i].
- gnt  out  NUM_PORTS  combinational grant; the request is accepted in the cycle where en[p] and gnt[p] are both 1.
- rd_valid  out  NUM_PORTS  one-cycle pulse; data_rd for that port is valid.
- data_rd  out  NUM_PORTS*DATA_WIDTH  per-port registered read data.
- addr_err  out  NUM_PORTS  one-cycle pulse; an out-of-range access was accepted.
- init_done  out  1  RAM is ready to accept requests.

Behaviour:
- Reset:
  - gnt, rd_valid, data_rd, addr_err and init_done are all 0.
  - Round-robin pointer is 0.
  - Memory contents are not reset, except as described under Optional Feature.
- Reset mid-operation clears any read in flight: rd_valid stays 0 and no data_rd update occurs.
- Arbitration:
  - At most one access per cycle.
  - gnt is one-hot or zero.
  - gnt is all-zero while init_done = 0.
  - The winner is the first port with en = 1, searching upward from the pointer and wrapping from NUM_PORTS-1 to 0.
  - On an accepted access, the pointer becomes (winner+1) mod NUM_PORTS. With no access, the pointer holds.
- Requester rules:
  - A requester holds en, wr_rdn, addr, data_wr and be stable until it is granted.
  - Deasserting en without a grant is legal and withdraws the request.
- Write:
  - Applied at the accepting edge.
  - Only bytes with be = 1 are updated.
  - be = 0 is a legal no-op write that still consumes the grant.
- Read:
  - Latency 1: in the cycle after acceptance, rd_valid[p] = 1 and data_rd[p] holds mem[addr].
  - data_rd[p] holds its value until the next accepted read on port p.
  - A read in the cycle after a write to the same address, from any port, returns the new data.
- Out of range (addr >= DEPTH):
  - The access is accepted and granted normally.
  - A write is dropped.
  - A read returns 0 with rd_valid.
  - addr_err[p] pulses in the cycle after acceptance.
- Back-to-back accesses from one port when it is the only requester: granted every cycle, full throughput.

Optional Feature:
- Macro: RAM_MP_CLEAR_EN.
- Defined:
  - After rstn deasserts, an init FSM (states INIT, READY) writes 0 to addresses 0..DEPTH-1, one per cycle.
  - gnt is held at 0 during INIT.
  - init_done rises on the cycle after the last clear write, i.e. DEPTH+1 edges after reset release.
  - Reset during INIT restarts the clear at address 0.
- Undefined:
  - No clear is performed and memory contents are undefined until written.
  - init_done becomes 1 on the first rising edge after rstn deasserts.

Test Plan:
- Single-port write/read:
  - Stimulus: NUM_PORTS=2. Port 0 writes 0xDEADBEEF to 0x155 with be=0xF, then reads 0x155.
  - Required: rd_valid[0] = 1 exactly one cycle after the read grant, data_rd[0] = 0xDEADBEEF, rd_valid[1] = 0 throughout.
- Byte enables:
  - Stimulus: write 0x11223344 to 0x010 with be=0xF, then write 0xAABBCCDD to 0x010 with be=0x5, then read 0x010.
  - Required: read returns 0x11BB33DD.
- Round-robin contention:
  - Stimulus: both ports hold en=1 for 4 cycles, starting from reset.
  - Required: gnt sequence 01, 10, 01, 10; each port receives exactly 2 grants.
- Out of range:
  - Stimulus: DEPTH=1000, port 1 writes 0x12345678 to 1000, then reads 1000.
  - Required: addr_err[1] pulses after each access, read data = 0, and address 999 is unchanged.
- Reset mid-read:
  - Stimulus: assert rstn=0 in the cycle after a read is accepted.
  - Required: rd_valid stays 0, data_rd = 0 and pointer = 0; previously written data at 0x155 is still readable after reset (macro undefined).
- Clear (macro defined):
  - Stimulus: DEPTH=16, release reset.
  - Required: init_done rises 17 edges after release, en is ignored before that, and a read of address 7 then returns 0.
